hmac_apb_dma_master: RTL and testbench

APB initiator that moves message words into, and hash words out of, the lw_sha APB slave on behalf of a streaming client.
- Sits between a valid/ready word stream and the slave's APB port, replacing the bench/CPU as bus master.
- Paces every transfer with the slave's dma_wr_req_o / dma_rd_req_o.
- Provides the autonomous other end of the APB wrapper for DMA-style message load and digest readout.

---
 rtl/hmac_apb_dma_pkg.sv | 22 ++
 rtl/hmac_apb_dma_master.sv | 190 +++++++++++++++++++
 tb/tb_hmac_apb_dma_master.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hmac_apb_dma_pkg.sv
// Shared definitions for the lw_sha APB DMA master.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: state_t encoding with its state constants, and the helper that
// derives the default per-word address increment from the data width.
package hmac_apb_dma_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_WAIT_REQ = 3'd1;
    localparam state_t ST_SETUP    = 3'd2;
    localparam state_t ST_ACCESS   = 3'd3;
    localparam state_t ST_HOLD     = 3'd4;
    localparam state_t ST_DONE     = 3'd5;

    // One word is DATA_W bits, so consecutive words sit DATA_W/8 bytes apart.
    function automatic int stride_default(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/hmac_apb_dma_master.sv
// APB initiator that streams message words into, and digest words out of, the lw_sha slave.
// Latency: min 3 cycles per word (WAIT_REQ, SETUP, ACCESS) plus pready wait states; reads add a HOLD cycle.
// Backpressure: paced by dma_wr_req_i/dma_rd_req_i and wvalid_i; a read word is held on rvalid_o until rready_i.
// Ports: command (cmd_*, abort_i), write stream (wdata_i/wvalid_i/wready_o),
//        read stream (rdata_o/rvalid_o/rready_i), slave pacing (dma_*_req_i),
//        APB master (paddr..pslverr), status (busy_o, done_o, err_o, xfer_cnt_o).
module hmac_apb_dma_master
    import hmac_apb_dma_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16,
    parameter int STRIDE = stride_default(DATA_W)
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_write_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [CNT_W-1:0]  cmd_len_i,
    input  logic              cmd_incr_i,
    input  logic              abort_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              wvalid_i,
    output logic              wready_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rvalid_o,
    input  logic              rready_i,
    input  logic              dma_wr_req_i,
    input  logic              dma_rd_req_i,
    output logic [ADDR_W-1:0] paddr,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [CNT_W-1:0]  xfer_cnt_o
);

    state_t            state_q, state_d;
    logic              write_q, write_d;
    logic              incr_q, incr_d;
    logic              err_q, err_d;
    logic              abort_q, abort_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ready_q;
    logic              done_q;
    logic              errp_q;
    logic              wready;

    logic [ADDR_W-1:0] addr_next;
    logic [CNT_W-1:0]  cnt_inc;
    logic              last_word;

    assign addr_next = addr_q + (incr_q ? ADDR_W'(STRIDE) : '0);
    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign last_word = (cnt_inc == len_q);

    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        incr_d   = incr_q;
        err_d    = err_q;
        abort_d  = abort_q;
        addr_d   = addr_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        pwdata_d = pwdata_q;
        rdata_d  = rdata_q;
        wready   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i && ready_q) begin
                    write_d = cmd_write_i;
                    addr_d  = cmd_addr_i;
                    len_d   = cmd_len_i;
                    incr_d  = cmd_incr_i;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    abort_d = 1'b0;
                    state_d = (cmd_len_i == '0) ? ST_DONE : ST_WAIT_REQ;
                end
            end
            ST_WAIT_REQ: begin
                if (abort_i) begin
                    state_d = ST_DONE;
                end else if (write_q) begin
                    if (dma_wr_req_i && wvalid_i) begin
                        wready   = 1'b1;
                        pwdata_d = wdata_i;
                        state_d  = ST_SETUP;
                    end
                end else if (dma_rd_req_i) begin
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                // An abort here cannot cut the bus cycle short; remember it.
                abort_d = abort_q | abort_i;
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                abort_d = abort_q | abort_i;
                if (pready) begin
                    if (pslverr) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (!write_q) begin
                        rdata_d = prdata;
                        // An aborted read finishes on the bus but is never delivered.
                        state_d = abort_d ? ST_DONE : ST_HOLD;
                    end else begin
                        cnt_d   = cnt_inc;
                        addr_d  = addr_next;
                        state_d = (last_word || abort_d) ? ST_DONE : ST_WAIT_REQ;
                    end
                end
            end
            ST_HOLD: begin
                if (abort_i) begin
                    state_d = ST_DONE;
                end else if (rready_i) begin
                    cnt_d   = cnt_inc;
                    addr_d  = addr_next;
                    state_d = last_word ? ST_DONE : ST_WAIT_REQ;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q  <= ST_IDLE;
            write_q  <= 1'b0;
            incr_q   <= 1'b0;
            err_q    <= 1'b0;
            abort_q  <= 1'b0;
            addr_q   <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            pwdata_q <= '0;
            rdata_q  <= '0;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
            errp_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            incr_q   <= incr_d;
            err_q    <= err_d;
            abort_q  <= abort_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            pwdata_q <= pwdata_d;
            rdata_q  <= rdata_d;
            // Registered so cmd_ready_o is low while reset is applied.
            ready_q  <= (state_d == ST_IDLE);
            done_q   <= (state_q == ST_DONE);
            errp_q   <= (state_q == ST_DONE) && err_q;
        end
    end

    assign cmd_ready_o = ready_q;
    assign wready_o    = wready;
    assign rdata_o     = rdata_q;
    assign rvalid_o    = (state_q == ST_HOLD);
    assign paddr       = addr_q;
    assign psel        = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign penable     = (state_q == ST_ACCESS);
    assign pwrite      = write_q;
    assign pwdata      = pwdata_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = done_q;
    assign err_o       = errp_q;
    assign xfer_cnt_o  = cnt_q;

endmodule

// File: tb/tb_hmac_apb_dma_master.sv
// Self-checking bench for hmac_apb_dma_master.
// Latency: n/a (bench).
// Backpressure: the bench models the APB slave, the pacing lines and both stream ends.
module tb_hmac_apb_dma_master;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    logic              pclk = 1'b0;
    logic              presetn;
    logic              cmd_valid_i, cmd_ready_o, cmd_write_i, cmd_incr_i, abort_i;
    logic [ADDR_W-1:0] cmd_addr_i;
    logic [CNT_W-1:0]  cmd_len_i;
    logic [DATA_W-1:0] wdata_i, rdata_o;
    logic              wvalid_i, wready_o, rvalid_o, rready_i;
    logic              dma_wr_req_i, dma_rd_req_i;
    logic [ADDR_W-1:0] paddr;
    logic              psel, penable, pwrite, pready, pslverr;
    logic [DATA_W-1:0] pwdata, prdata;
    logic              busy_o, done_o, err_o;
    logic [CNT_W-1:0]  xfer_cnt_o;

    hmac_apb_dma_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .pclk(pclk), .presetn(presetn),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
        .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i), .cmd_incr_i(cmd_incr_i),
        .abort_i(abort_i), .wdata_i(wdata_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
        .rdata_o(rdata_o), .rvalid_o(rvalid_o), .rready_i(rready_i),
        .dma_wr_req_i(dma_wr_req_i), .dma_rd_req_i(dma_rd_req_i),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .xfer_cnt_o(xfer_cnt_o)
    );

    always #5 pclk = ~pclk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              wr;
        logic [DATA_W-1:0] dat;
    } beat_t;

    int vectors = 0;
    int miscompares = 0;

    beat_t             exp_apb[$];
    logic [DATA_W-1:0] exp_rd[$];
    logic [DATA_W-1:0] wwords[$];

    // Slave / environment knobs (-1 or empty window = inactive).
    int slv_wait, err_beat, abort_beat, hold_beat, stall_lo, stall_hi;

    // Results gathered by run_cmd.
    bit               done_seen;
    int               done_cyc, beats, rd_cnt, pen_cycles, psel_cycles, stall_viol;
    logic             err_at_done, busy_at_done;
    logic [CNT_W-1:0] cnt_at_done;

    function automatic logic [DATA_W-1:0] rd_model(input logic [ADDR_W-1:0] a);
        return {8'hC3, 12'hABC, a};
    endfunction

    task automatic knobs_default();
        slv_wait = 0; err_beat = -1; abort_beat = -1; hold_beat = -1;
        stall_lo = 0; stall_hi = 0;
        exp_apb.delete(); exp_rd.delete(); wwords.delete();
    endtask

    // Issues one command, acts as APB slave and stream endpoints, and pops the
    // scoreboard on every completed APB beat and read-stream handshake.
    task automatic run_cmd(input logic wr, input logic [ADDR_W-1:0] a,
                           input logic [CNT_W-1:0] len, input logic incr);
        int    widx, acc_k, n;
        bit    w_hs;
        beat_t e;
        logic [DATA_W-1:0] er;
        widx = 0; acc_k = 0; n = 0; w_hs = 0;
        done_seen = 0; done_cyc = 0; beats = 0; rd_cnt = 0;
        pen_cycles = 0; psel_cycles = 0; stall_viol = 0;
        err_at_done = 0; busy_at_done = 0; cnt_at_done = '0;
        @(negedge pclk);
        cmd_write_i = wr; cmd_addr_i = a; cmd_len_i = len; cmd_incr_i = incr;
        cmd_valid_i = 1'b1;
        while (!cmd_ready_o && n < 50) begin
            @(negedge pclk);
            n++;
        end
        for (int cyc = 1; cyc <= 400 && !done_seen; cyc++) begin
            @(negedge pclk);
            cmd_valid_i = 1'b0;
            if (w_hs) widx++;
            wvalid_i = wr && (widx < wwords.size());
            wdata_i  = (widx < wwords.size()) ? wwords[widx] : '0;
            dma_wr_req_i = !(cyc >= stall_lo && cyc < stall_hi);
            dma_rd_req_i = 1'b1;
            if (psel && penable) begin
                acc_k++;
                pready = (acc_k > slv_wait);
            end else begin
                acc_k = 0;
                pready = 1'b0;
            end
            prdata   = rd_model(paddr);
            pslverr  = pready && (beats == err_beat);
            rready_i = !(rvalid_o && rd_cnt == hold_beat);
            abort_i  = (psel && penable && acc_k == 1 && beats == abort_beat) ||
                       (rvalid_o && rd_cnt == hold_beat);
            #1;
            w_hs = wready_o && wvalid_i;
            if (penable) pen_cycles++;
            if (psel) psel_cycles++;
            if (psel && cyc >= stall_lo && cyc < stall_hi) stall_viol++;
            if (psel && penable && pready) begin
                vectors++;
                if (exp_apb.size() == 0) begin
                    miscompares++;
                    $display("FAIL apb_extra: unexpected transfer addr=%h wr=%b", paddr, pwrite);
                end else begin
                    e = exp_apb.pop_front();
                    if (paddr !== e.addr || pwrite !== e.wr || (e.wr && pwdata !== e.dat)) begin
                        miscompares++;
                        $display("FAIL apb_beat: got addr=%h wr=%b data=%h, want addr=%h wr=%b data=%h",
                                 paddr, pwrite, pwdata, e.addr, e.wr, e.dat);
                    end
                end
                beats++;
            end
            if (rvalid_o && rready_i) begin
                vectors++;
                er = (exp_rd.size() != 0) ? exp_rd.pop_front() : 'x;
                if (rdata_o !== er) begin
                    miscompares++;
                    $display("FAIL rd_stream: got %h want %h", rdata_o, er);
                end
                rd_cnt++;
            end
            if (done_o) begin
                done_seen = 1; done_cyc = cyc; err_at_done = err_o;
                busy_at_done = busy_o; cnt_at_done = xfer_cnt_o;
            end
        end
        wvalid_i = 1'b0; abort_i = 1'b0; pready = 1'b0; pslverr = 1'b0; rready_i = 1'b1;
        vectors++;
        if (!done_seen) begin
            miscompares++;
            $display("FAIL done_timeout: done_o not seen within cycle budget");
        end
        vectors++;
        if (exp_apb.size() != 0 || exp_rd.size() != 0) begin
            miscompares++;
            $display("FAIL missing_beats: %0d apb and %0d read entries left", exp_apb.size(), exp_rd.size());
        end
    endtask

    task automatic test_reset();
        presetn = 1'b1;
        cmd_valid_i = 0; cmd_write_i = 0; cmd_addr_i = '0; cmd_len_i = '0; cmd_incr_i = 0;
        abort_i = 0; wdata_i = '0; wvalid_i = 0; rready_i = 1; dma_wr_req_i = 0; dma_rd_req_i = 0;
        prdata = '0; pready = 0; pslverr = 0;
        #2 presetn = 1'b0;
        @(negedge pclk);
        vectors++;
        if ({psel, penable, busy_o, done_o, err_o, cmd_ready_o, wready_o, rvalid_o} !== 8'b0 ||
            xfer_cnt_o !== '0 || paddr !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: psel=%b penable=%b busy=%b done=%b err=%b ready=%b cnt=%0d paddr=%h, want all 0",
                     psel, penable, busy_o, done_o, err_o, cmd_ready_o, xfer_cnt_o, paddr);
        end
        presetn = 1'b1;
        @(negedge pclk);
        vectors++;
        if (cmd_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_after_reset: got %b want 1", cmd_ready_o);
        end
    endtask

    task automatic test_write_fixed();
        knobs_default();
        for (int i = 0; i < 4; i++) begin
            wwords.push_back(32'hA0 + i);
            exp_apb.push_back('{addr: 12'h040, wr: 1'b1, dat: 32'hA0 + i});
        end
        run_cmd(1'b1, 12'h040, 16'd4, 1'b0);
        vectors++;
        if (cnt_at_done !== 16'd4 || err_at_done !== 1'b0 || busy_at_done !== 1'b0 || done_cyc != 14) begin
            miscompares++;
            $display("FAIL write_fixed_end: cnt=%0d err=%b busy=%b done_cyc=%0d, want 4 0 0 14",
                     cnt_at_done, err_at_done, busy_at_done, done_cyc);
        end
    endtask

    task automatic test_read_incr();
        knobs_default();
        slv_wait = 2;
        for (int i = 0; i < 8; i++) begin
            exp_apb.push_back('{addr: 12'h080 + 12'(4 * i), wr: 1'b0, dat: '0});
            exp_rd.push_back(rd_model(12'h080 + 12'(4 * i)));
        end
        run_cmd(1'b0, 12'h080, 16'd8, 1'b1);
        vectors++;
        if (cnt_at_done !== 16'd8 || pen_cycles != 24 || done_cyc != 50) begin
            miscompares++;
            $display("FAIL read_incr_end: cnt=%0d penable_cycles=%0d done_cyc=%0d, want 8 24 50",
                     cnt_at_done, pen_cycles, done_cyc);
        end
    endtask

    task automatic test_stall();
        knobs_default();
        stall_lo = 4; stall_hi = 14;
        for (int i = 0; i < 4; i++) begin
            wwords.push_back(32'h5100_0000 + i);
            exp_apb.push_back('{addr: 12'h100 + 12'(4 * i), wr: 1'b1, dat: 32'h5100_0000 + i});
        end
        run_cmd(1'b1, 12'h100, 16'd4, 1'b1);
        vectors++;
        if (stall_viol != 0 || cnt_at_done !== 16'd4 || done_cyc != 24) begin
            miscompares++;
            $display("FAIL stall: psel_in_stall=%0d cnt=%0d done_cyc=%0d, want 0 4 24",
                     stall_viol, cnt_at_done, done_cyc);
        end
    endtask

    task automatic test_slverr();
        knobs_default();
        err_beat = 1;
        for (int i = 0; i < 5; i++) wwords.push_back(32'hE000_0000 + i);
        for (int i = 0; i < 2; i++)
            exp_apb.push_back('{addr: 12'h020, wr: 1'b1, dat: 32'hE000_0000 + i});
        run_cmd(1'b1, 12'h020, 16'd5, 1'b0);
        vectors++;
        if (err_at_done !== 1'b1 || cnt_at_done !== 16'd1 || beats != 2 || done_cyc != 8) begin
            miscompares++;
            $display("FAIL slverr: err=%b cnt=%0d beats=%0d done_cyc=%0d, want 1 1 2 8",
                     err_at_done, cnt_at_done, beats, done_cyc);
        end
    endtask

    task automatic test_abort_access();
        knobs_default();
        abort_beat = 2;
        for (int i = 0; i < 5; i++) wwords.push_back(32'hAB00_0000 + i);
        for (int i = 0; i < 3; i++)
            exp_apb.push_back('{addr: 12'h200 + 12'(4 * i), wr: 1'b1, dat: 32'hAB00_0000 + i});
        run_cmd(1'b1, 12'h200, 16'd5, 1'b1);
        vectors++;
        if (cnt_at_done !== 16'd3 || err_at_done !== 1'b0 || done_cyc != 11) begin
            miscompares++;
            $display("FAIL abort_access: cnt=%0d err=%b done_cyc=%0d, want 3 0 11",
                     cnt_at_done, err_at_done, done_cyc);
        end
    endtask

    task automatic test_abort_hold();
        knobs_default();
        hold_beat = 2;
        for (int i = 0; i < 3; i++)
            exp_apb.push_back('{addr: 12'hFF8 + 12'(4 * i), wr: 1'b0, dat: '0});
        for (int i = 0; i < 2; i++) exp_rd.push_back(rd_model(12'hFF8 + 12'(4 * i)));
        run_cmd(1'b0, 12'hFF8, 16'd5, 1'b1);   // also crosses the 12-bit address wrap
        vectors++;
        if (cnt_at_done !== 16'd2 || rd_cnt != 2 || done_cyc != 14) begin
            miscompares++;
            $display("FAIL abort_hold: cnt=%0d delivered=%0d done_cyc=%0d, want 2 2 14",
                     cnt_at_done, rd_cnt, done_cyc);
        end
    endtask

    task automatic test_zero_len();
        knobs_default();
        run_cmd(1'b1, 12'h300, 16'd0, 1'b1);
        vectors++;
        if (done_cyc != 2 || psel_cycles != 0 || cnt_at_done !== 16'd0) begin
            miscompares++;
            $display("FAIL zero_len: done_cyc=%0d psel_cycles=%0d cnt=%0d, want 2 0 0",
                     done_cyc, psel_cycles, cnt_at_done);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        knobs_default();
        n = 0;
        @(negedge pclk);
        cmd_write_i = 1; cmd_addr_i = 12'h010; cmd_len_i = 16'd2; cmd_incr_i = 1; cmd_valid_i = 1;
        wdata_i = 32'h1234_5678; wvalid_i = 1; dma_wr_req_i = 1; pready = 0;
        while (!(psel && penable) && n < 20) begin
            @(negedge pclk);
            if (busy_o) cmd_valid_i = 0;
            n++;
        end
        vectors++;
        if (!(psel && penable)) begin
            miscompares++;
            $display("FAIL reset_mid_reach: ACCESS not reached, psel=%b penable=%b", psel, penable);
        end
        #2 presetn = 1'b0;
        #1;
        vectors++;
        if (psel !== 1'b0 || penable !== 1'b0 || busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid: psel=%b penable=%b busy=%b, want 0 0 0", psel, penable, busy_o);
        end
        cmd_valid_i = 0; wvalid_i = 0;
        @(negedge pclk);
        presetn = 1'b1;
        // The discarded command must not resurface; a fresh one runs normally.
        wwords.push_back(32'hC0FF_EE00);
        exp_apb.push_back('{addr: 12'h050, wr: 1'b1, dat: 32'hC0FF_EE00});
        run_cmd(1'b1, 12'h050, 16'd1, 1'b0);
        vectors++;
        if (cnt_at_done !== 16'd1) begin
            miscompares++;
            $display("FAIL reset_recover: cnt=%0d want 1", cnt_at_done);
        end
    endtask

    initial begin
        test_reset();
        test_write_fixed();
        test_read_incr();
        test_stall();
        test_slverr();
        test_abort_access();
        test_abort_hold();
        test_zero_len();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
